// File: rtl/hex_scan_controller.sv
// hex_scan_controller
//   Time-multiplexes one shared 4-bit -> 7-segment decoder across DIGITS
//   common-anode digits. A shadow buffer takes new display values at any time;
//   they are committed to the active buffer only at the start of a frame, so a
//   value never changes mid-frame. Each digit slot is a BLANK gap (all digits
//   dark, decoder input already settled) followed by an ON dwell.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   load          1-cycle strobe: capture load_val into the shadow buffer
//   load_val      display value, nibble k shown on digit k
//   blank_mask    bit k=1 keeps digit k dark (its slot is still consumed)
//   seg_in        active-low segments {g,f,e,d,c,b,a} from the shared decoder
//   dec_val       nibble presented to the shared decoder
//   seg_out       active-low segment bus
//   dig_sel       active-low digit enables, at most one bit low
//   load_ack      1-cycle pulse the cycle after each accepted load
//   frame_start   1-cycle pulse on entering ON for digit 0
module hex_scan_controller #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DWELL     = 50000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [6:0]            seg_in,
    output logic [3:0]            dec_val,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  load_ack,
    output logic                  frame_start
);

    localparam int unsigned TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {StBlank, StOn} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TW-1:0]        r_timer;
    logic [IW-1:0]        r_dig_idx;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [4*DIGITS-1:0]  r_active;
    logic                 r_pending;
    logic                 r_load_ack;
    logic                 r_frame_start;

    logic                 w_blank_done;
    logic                 w_dwell_done;
    logic                 w_commit;

    assign w_blank_done = (r_state == StBlank) && (r_timer == BLANK_LAST);
    assign w_dwell_done = (r_state == StOn) && (r_timer == DWELL_LAST);
    // Frame boundary: leaving the gap in front of digit 0.
    assign w_commit     = w_blank_done && (r_dig_idx == '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StBlank;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StBlank: if (w_blank_done) w_state_next = StOn;
            StOn:    if (w_dwell_done) w_state_next = StBlank;
            default: w_state_next = StBlank;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Only the current digit can be pulled low, and only in ON.
    // ------------------------------------------------------------------
    always_comb begin
        dig_sel = '1;
        seg_out = 7'h7F;
        if (r_state == StOn) begin
            for (int k = 0; k < DIGITS; k++) begin
                if ((r_dig_idx == IW'(k)) && !blank_mask[k]) begin
                    dig_sel[k] = 1'b0;
                    seg_out    = seg_in;
                end
            end
        end
    end

    // Decoder input follows dig_idx in both states so it is settled during BLANK.
    always_comb begin
        dec_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_dig_idx == IW'(k)) begin
                dec_val = r_active[4*k +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot timer and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_dig_idx <= '0;
        end else begin
            if (w_blank_done || w_dwell_done) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_dwell_done) begin
                r_dig_idx <= (r_dig_idx == IDX_LAST) ? '0 : r_dig_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer. On a load coinciding with a commit, active takes the
    // old shadow and the new value stays pending for the next frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_pending     <= 1'b0;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_load_ack    <= load;
            r_frame_start <= w_commit;
            if (w_commit && r_pending) begin
                r_active <= r_shadow;
            end
            if (load) begin
                r_shadow  <= load_val;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign load_ack    = r_load_ack;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_scan_controller.sv
module tb_hex_scan_controller;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLANK  = 2;
    localparam int          SLOT   = DWELL + BLANK;   // 6
    localparam int          FRAME  = DIGITS * SLOT;   // 24

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  blank_mask;
    logic [6:0]  seg_in;
    logic [3:0]  dec_val;
    logic [6:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        load_ack;
    logic        frame_start;

    hex_scan_controller #(
        .DIGITS   (DIGITS),
        .DWELL    (DWELL),
        .BLANK_CYC(BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_val),
        .blank_mask (blank_mask),
        .seg_in     (seg_in),
        .dec_val    (dec_val),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .load_ack   (load_ack),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Active-low {g,f,e,d,c,b,a} hex font.
    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'h0: dec7 = 7'b1000000;
            4'h1: dec7 = 7'b1111001;
            4'h2: dec7 = 7'b0100100;
            4'h3: dec7 = 7'b0110000;
            4'h4: dec7 = 7'b0011001;
            4'h5: dec7 = 7'b0010010;
            4'h6: dec7 = 7'b0000010;
            4'h7: dec7 = 7'b1111000;
            4'h8: dec7 = 7'b0000000;
            4'h9: dec7 = 7'b0010000;
            4'hA: dec7 = 7'b0001000;
            4'hB: dec7 = 7'b0000011;
            4'hC: dec7 = 7'b1000110;
            4'hD: dec7 = 7'b0100001;
            4'hE: dec7 = 7'b0000110;
            default: dec7 = 7'b0001110;
        endcase
    endfunction

    // Shared external decoder, purely combinational.
    always_comb seg_in = dec7(dec_val);

    typedef struct {
        int         t;
        logic [3:0] dv;
        logic [6:0] seg;
        logic [3:0] sel;
        logic       ack;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Expected-display bookkeeping, in frame-position terms.
    int          t;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pend;

    task automatic push_exp(input logic in_rst, input logic ack, input logic fs);
        exp_t e;
        int   pos;
        int   slot;
        e.t = t;
        if (in_rst) begin
            e.dv = 4'h0; e.seg = 7'h7F; e.sel = 4'hF; e.ack = 1'b0; e.fs = 1'b0;
        end else begin
            pos  = t % FRAME;
            slot = pos / SLOT;
            e.dv  = m_active[4*slot +: 4];
            e.ack = ack;
            e.fs  = fs;
            if ((pos % SLOT) >= BLANK && !blank_mask[slot]) begin
                e.sel = 4'hF;
                e.sel[slot] = 1'b0;
                e.seg = dec7(e.dv);
            end else begin
                e.sel = 4'hF;
                e.seg = 7'h7F;
            end
        end
        q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (dec_val !== e.dv || seg_out !== e.seg || dig_sel !== e.sel ||
                load_ack !== e.ack || frame_start !== e.fs) begin
                n_bad++;
                $display("FAIL scan t=%0d: got dv=%h seg=%b sel=%b ack=%b fs=%b, want dv=%h seg=%b sel=%b ack=%b fs=%b",
                         e.t, dec_val, seg_out, dig_sel, load_ack, frame_start,
                         e.dv, e.seg, e.sel, e.ack, e.fs);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int   phase;
        int   hold;
        logic ack_e;
        logic fs_e;
        rst = 1'b1; load = 1'b0; load_val = 16'h0; blank_mask = 4'h0;
        phase = 0; hold = 0;
        t = 0; m_active = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 170; n++) begin
            @(posedge clk);
            if (rst) begin
                hold++;
                #1;
                if (hold == 2) begin
                    rst = 1'b0;
                    phase = 1;
                    t = 0; m_active = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
                    push_exp(1'b0, 1'b0, 1'b0);
                end else begin
                    push_exp(1'b1, 1'b0, 1'b0);
                end
            end else begin
                // Effect of the edge just taken, using the inputs it sampled.
                t++;
                fs_e  = (t % FRAME) == 2;
                ack_e = load;
                if (fs_e && m_pend) begin
                    m_active = m_shadow;
                    m_pend   = 1'b0;
                end
                if (load) begin
                    m_shadow = load_val;
                    m_pend   = 1'b1;
                end
                #1;
                load = 1'b0;
                if (phase == 0) begin
                    case (t)
                        10:  begin load = 1'b1; load_val = 16'h4A1F; end
                        40:  begin load = 1'b1; load_val = 16'h1111; end
                        41:  begin load = 1'b1; load_val = 16'h2222; end
                        49:  begin load = 1'b1; load_val = 16'h3333; end
                        72:  blank_mask = 4'b0100;
                        96:  blank_mask = 4'b0000;
                        100: begin load = 1'b1; load_val = 16'h5555; end
                        111: rst = 1'b1;
                        default: ;
                    endcase
                end
                push_exp(rst, ack_e, fs_e);
            end
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
